// File: rtl/exception_controller_if.sv
// exception_controller_if
//   Groups the exception request/acknowledge handshake, the software
//   control inputs and the status outputs of exception_controller.
//   The controller connects through the slave modport. The pipeline and
//   software side that drives triggers, masks, clears, acks and returns
//   connects through the master modport.
//
//   exceptionIn   [15:0]  one-cycle trigger pulses, bit n = exception n
//   exceptionMask [15:0]  per-exception enable (1 = enabled)
//   globalEnable          master dispatch enable
//   clearPending  [15:0]  software clear of pending bits
//   excAck                pipeline accepts the current request
//   excReturn             handler finished
//   excReq                dispatch request to the pipeline
//   excVector     [3:0]   index of the dispatched exception
//   inService             a handler is active
//   pending       [15:0]  current pending register
interface exception_controller_if;
    logic [15:0] exceptionIn;
    logic [15:0] exceptionMask;
    logic        globalEnable;
    logic [15:0] clearPending;
    logic        excAck;
    logic        excReturn;
    logic        excReq;
    logic [3:0]  excVector;
    logic        inService;
    logic [15:0] pending;

    modport slave (
        input  exceptionIn, exceptionMask, globalEnable, clearPending,
               excAck, excReturn,
        output excReq, excVector, inService, pending
    );

    modport master (
        output exceptionIn, exceptionMask, globalEnable, clearPending,
               excAck, excReturn,
        input  excReq, excVector, inService, pending
    );
endinterface

// File: rtl/exception_controller.sv
// exception_controller
//   Collects 16 exception trigger pulses into a pending register and
//   dispatches the highest-priority enabled one (lowest index wins) to
//   the pipeline with a request/acknowledge handshake. After an
//   acknowledge the block stays in service until the handler returns.
//   Dispatch is not preemptive: once a request is raised, its vector
//   holds until it is acknowledged. Every output comes from a register.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    exception_controller_if.slave (triggers, masks, clears,
//          ack/return handshake in; excReq, excVector, inService,
//          pending out)
module exception_controller (
    input  logic                        clk,
    input  logic                        reset,
    exception_controller_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] pending_q;
    logic [15:0] pending_next;
    logic [15:0] eligible;
    logic [15:0] ack_clear;
    logic [3:0]  winner;

    logic [3:0]  vector_q;
    logic [3:0]  vector_next;
    logic        req_q;
    logic        req_next;
    logic        in_service_q;
    logic        in_service_next;

    // Candidates for dispatch: enabled pending bits, gated by the master enable.
    assign eligible = bus.globalEnable ? (pending_q & bus.exceptionMask) : 16'h0000;

    // Fixed priority: scanning from the top down leaves the lowest set index.
    always_comb begin
        winner = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 4'(i);
            end
        end
    end

    // An accepted acknowledge retires the requested bit; a new trigger on
    // the same bit in the same cycle is applied last, so it survives.
    assign ack_clear    = (state == REQUEST && bus.excAck) ? (16'h0001 << vector_q) : 16'h0000;
    assign pending_next = (pending_q & ~bus.clearPending & ~ack_clear) | bus.exceptionIn;

    // Next-state and next-output logic. The outputs are computed here and
    // then registered, so no input reaches an output combinationally.
    always_comb begin
        // NOTE: every signal written in this block gets a default first; a
        // path that skips an assignment would otherwise infer a latch.
        state_next      = state;
        vector_next     = vector_q;
        req_next        = req_q;
        in_service_next = in_service_q;

        unique case (state)
            IDLE: begin
                if (eligible != 16'h0000) begin
                    vector_next = winner;
                    req_next    = 1'b1;
                    state_next  = REQUEST;
                end
            end
            REQUEST: begin
                // Request and vector hold regardless of new arrivals,
                // masking or clears until the pipeline accepts.
                if (bus.excAck) begin
                    req_next        = 1'b0;
                    in_service_next = 1'b1;
                    state_next      = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.excReturn) begin
                    in_service_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                req_next        = 1'b0;
                in_service_next = 1'b0;
                state_next      = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending_q    <= 16'h0000;
            vector_q     <= 4'h0;
            req_q        <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state        <= state_next;
            pending_q    <= pending_next;
            vector_q     <= vector_next;
            req_q        <= req_next;
            in_service_q <= in_service_next;
        end
    end

    assign bus.excReq    = req_q;
    assign bus.excVector = vector_q;
    assign bus.inService = in_service_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_exception_controller.sv
// tb_exception_controller
//   Directed stimulus for exception_controller. A behavioural model of the
//   dispatch rules is compared against the DUT on every falling edge while
//   reset is low; literal expectations at key points pin the model itself.
module tb_exception_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    exception_controller_if bus ();

    exception_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_pending = 16'h0000;
    logic [3:0]  m_vec     = 4'h0;
    bit          m_req     = 1'b0;   // request outstanding
    bit          m_svc     = 1'b0;   // handler running

    function automatic int lowest_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pending <= 16'h0000;
            m_vec     <= 4'h0;
            m_req     <= 1'b0;
            m_svc     <= 1'b0;
        end else begin
            logic [15:0] elig;
            logic [15:0] retire;
            elig   = bus.globalEnable ? (m_pending & bus.exceptionMask) : 16'h0000;
            retire = 16'h0000;
            if (m_req && bus.excAck) retire[m_vec] = 1'b1;
            m_pending <= (m_pending & ~bus.clearPending & ~retire) | bus.exceptionIn;
            if (m_req) begin
                if (bus.excAck) begin
                    m_req <= 1'b0;
                    m_svc <= 1'b1;
                end
            end else if (m_svc) begin
                if (bus.excReturn) m_svc <= 1'b0;
            end else if (elig != 16'h0000) begin
                m_vec <= 4'(lowest_set(elig));
                m_req <= 1'b1;
            end
        end
    end

    // Outputs only move on a rising edge or reset, so the falling edge is a safe sample point.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_excReq",    32'(bus.excReq),    32'(m_req));
            check("cmp_excVector", 32'(bus.excVector), 32'(m_vec));
            check("cmp_inService", 32'(bus.inService), 32'(m_svc));
            check("cmp_pending",   32'(bus.pending),   32'(m_pending));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        bus.exceptionIn   = 16'h0000;
        bus.exceptionMask = 16'hFFFF;
        bus.globalEnable  = 1'b1;
        bus.clearPending  = 16'h0000;
        bus.excAck        = 1'b0;
        bus.excReturn     = 1'b0;

        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_excReq",    32'(bus.excReq),    32'd0);
        check("rst_excVector", 32'(bus.excVector), 32'd0);
        check("rst_inService", 32'(bus.inService), 32'd0);
        check("rst_pending",   32'(bus.pending),   32'h0000);

        // Two triggers; bit 3 wins, bit 5 follows after return.
        bus.exceptionIn = 16'h0028; step(); bus.exceptionIn = 16'h0000;
        check("a_pending_1cyc", 32'(bus.pending), 32'h0028);
        check("a_req_1cyc",     32'(bus.excReq),  32'd0);
        step();
        check("a_req_2cyc", 32'(bus.excReq),    32'd1);
        check("a_vec_2cyc", 32'(bus.excVector), 32'd3);
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        check("a_pending_ack", 32'(bus.pending),   32'h0020);
        check("a_insvc_ack",   32'(bus.inService), 32'd1);
        check("a_req_ack",     32'(bus.excReq),    32'd0);
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;
        check("a_insvc_ret", 32'(bus.inService), 32'd0);
        step();
        check("a_req_next", 32'(bus.excReq),    32'd1);
        check("a_vec_next", 32'(bus.excVector), 32'd5);

        // Higher-priority arrival while a request is held does not preempt.
        bus.exceptionIn = 16'h0001; step(); bus.exceptionIn = 16'h0000;
        check("b_vec_hold1", 32'(bus.excVector), 32'd5);
        step();
        check("b_vec_hold2", 32'(bus.excVector), 32'd5);
        check("b_req_hold2", 32'(bus.excReq),    32'd1);
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        check("b_pending_ack", 32'(bus.pending), 32'h0001);
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;
        step();
        check("b_vec_0", 32'(bus.excVector), 32'd0);
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;
        check("b_pending_empty", 32'(bus.pending), 32'h0000);

        // Masked trigger waits in pending until enabled.
        bus.exceptionMask = 16'h0000;
        bus.exceptionIn = 16'h8000; step(); bus.exceptionIn = 16'h0000;
        step();
        check("c_pending_masked", 32'(bus.pending), 32'h8000);
        check("c_req_masked",     32'(bus.excReq),  32'd0);
        bus.exceptionMask = 16'h8000; step();
        check("c_req_unmask", 32'(bus.excReq),    32'd1);
        check("c_vec_unmask", 32'(bus.excVector), 32'd15);
        bus.exceptionMask = 16'h0000; bus.globalEnable = 1'b0; step();
        check("c_req_no_withdraw", 32'(bus.excReq), 32'd1);
        bus.exceptionMask = 16'hFFFF; bus.globalEnable = 1'b1;
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;

        // Set beats clear, and set beats acknowledge retirement.
        bus.exceptionIn = 16'h0004; bus.clearPending = 16'h0004; step();
        bus.exceptionIn = 16'h0000; bus.clearPending = 16'h0000;
        check("d_set_beats_clear", 32'(bus.pending), 32'h0004);
        step();
        check("d_vec_2", 32'(bus.excVector), 32'd2);
        bus.excAck = 1'b1; bus.exceptionIn = 16'h0004; step();
        bus.excAck = 1'b0; bus.exceptionIn = 16'h0000;
        check("d_set_beats_ack", 32'(bus.pending),   32'h0004);
        check("d_insvc",         32'(bus.inService), 32'd1);
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;
        step();
        check("d_redispatch", 32'(bus.excReq), 32'd1);
        bus.clearPending = 16'h0004; step(); bus.clearPending = 16'h0000;
        check("d_clear_in_req_pending", 32'(bus.pending),   32'h0000);
        check("d_clear_in_req_req",     32'(bus.excReq),    32'd1);
        check("d_clear_in_req_vec",     32'(bus.excVector), 32'd2);
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;

        // Stray return in IDLE and stray ack in SERVICE are ignored.
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;
        check("e_ret_idle_req",   32'(bus.excReq),    32'd0);
        check("e_ret_idle_insvc", 32'(bus.inService), 32'd0);
        bus.exceptionIn = 16'h0002; step(); bus.exceptionIn = 16'h0000;
        step();
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        bus.exceptionIn = 16'h0100; step(); bus.exceptionIn = 16'h0000;
        check("e_accumulate", 32'(bus.pending), 32'h0100);
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        check("e_ack_svc_pending", 32'(bus.pending),   32'h0100);
        check("e_ack_svc_insvc",   32'(bus.inService), 32'd1);
        step();
        check("e_no_dispatch_svc", 32'(bus.excReq), 32'd0);

        // Asynchronous reset mid-cycle in SERVICE; a trigger during reset is lost.
        #2 reset = 1'b1;
        #1;
        check("f_async_req",     32'(bus.excReq),    32'd0);
        check("f_async_vec",     32'(bus.excVector), 32'd0);
        check("f_async_insvc",   32'(bus.inService), 32'd0);
        check("f_async_pending", 32'(bus.pending),   32'h0000);
        bus.exceptionIn = 16'h0001; step(); step(); bus.exceptionIn = 16'h0000;
        step();
        reset = 1'b0;
        step(); step();
        check("f_no_req_after", 32'(bus.excReq),  32'd0);
        check("f_pending_lost", 32'(bus.pending), 32'h0000);
        bus.exceptionIn = 16'h0040; step(); bus.exceptionIn = 16'h0000;
        step();
        check("f_first_req", 32'(bus.excReq),    32'd1);
        check("f_first_vec", 32'(bus.excVector), 32'd6);
        bus.excAck = 1'b1; step(); bus.excAck = 1'b0;
        bus.excReturn = 1'b1; step(); bus.excReturn = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
